sqr_wav_meas: RTL and testbench
===============================

# sqr_wav_meas

Square-wave measurement stage that sits directly downstream of `sqr_wav_gen`. It samples the generator's `sqr_state` output and measures each complete high/low period in 100 ns units, so the values are directly comparable with the generator's `high_m`/`low_n` settings. Each result is published through a valid/ready handshake. The block also flags a stuck output, which is what the generator produces when `high_m` or `low_n` is 0. It is used as a closed-loop self-check of the generator and as a general pulse-timing monitor.

## Interface
Parameters:
- `SQR_STATE_NS`, 100: measurement unit in ns.
- `CLK_NS`, 10: system clock period in ns. `DIV = SQR_STATE_NS/CLK_NS` must be an integer ≥ 2.
- `TIMEOUT_UNITS`, 20: number of units without an edge before stuck is declared. Must be greater than 15.

Ports:
- `clk`, in, 1: system clock. This is the one clock, and all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sqr_in`, in, 1: square wave, normally `sqr_wav_gen.sqr_state`.
- `meas_ready`, in, 1: consumer accepts the result.
- `meas_valid`, out, 1: result held and available.
- `high_m_meas`, out, 4: measured high time in units.
- `low_n_meas`, out, 4: measured low time in units.
- `overrun`, out, 1: sticky flag; a completed period was dropped.
- `stuck_hi`, out, 1: `sqr_in` has stayed high for at least `TIMEOUT_UNITS` units.
- `stuck_lo`, out, 1: `sqr_in` has stayed low for at least `TIMEOUT_UNITS` units.

## Operation
- Input sampling:
  - `sqr_in` is registered into `prev`.
  - An edge is the cycle in which `sqr_in != prev`: a rise when `sqr_in=1`, a fall when `sqr_in=0`.
- Phase counter:
  - `cyc` is the number of consecutive cycles `sqr_in` has been sampled at its current level. The edge cycle counts as 1.
  - Phase length is `floor(cyc/DIV)`, saturating at 15.
  - The internal unit count saturates at `TIMEOUT_UNITS`.
- FSM states: WAIT, MEAS_HI, MEAS_LO. Reset enters WAIT.
  - WAIT: on a rise, go to MEAS_HI and start counting. The partial phase after reset is discarded.
  - MEAS_HI: on a fall, latch the high length into `hi_hold` and go to MEAS_LO.
  - MEAS_LO: on a rise, latch the low length and publish `{hi_hold, low}`, then go to MEAS_HI.
- Stuck detection:
  - In MEAS_HI, or in WAIT with `sqr_in=1`: when the unit count reaches `TIMEOUT_UNITS`, set `stuck_hi`.
  - In MEAS_LO, or in WAIT with `sqr_in=0`: when the unit count reaches `TIMEOUT_UNITS`, set `stuck_lo`.
  - In either case the FSM returns to WAIT and nothing is published.
  - Both flags clear on the next edge of `sqr_in`.
- Publish rules:
  - If `meas_valid=0`, or a transfer (`meas_valid & meas_ready`) occurs in the same cycle: load the new outputs and keep `meas_valid=1`. `overrun` is not set.
  - If `meas_valid=1` and `meas_ready=0`: keep the held data, drop the new result, and set `overrun`.
  - A transfer with no publish in the same cycle clears `meas_valid` on the next cycle.
  - `overrun` clears on the cycle after any transfer.
- Output data is stable while `meas_valid=1 & meas_ready=0`.

## Timing
- Reset values: `meas_valid=0`, `high_m_meas=0`, `low_n_meas=0`, `overrun=0`, `stuck_hi=0`, `stuck_lo=0`, state WAIT, `prev=0`, counters 0.
- Reset asserted mid-measurement aborts the measurement immediately and asynchronously. No result is published afterwards until one full high phase and one full low phase have been measured.
- Latency:
  - A rise sampled at cycle t gives `meas_valid`/data at t+1.
  - Stuck flags assert 1 cycle after the unit count reaches `TIMEOUT_UNITS`.
- All outputs are registered, with no combinational path from input to output.
- Minimum measurable phase is 1 cycle, which reports 0 units. A phase shorter than `DIV` cycles reports 0.

## Configuration
- `SQR_MEAS_SYNC_EN` defined:
  - A 2-flop synchronizer is inserted on `sqr_in` for asynchronous or external sources.
  - All edge-related latencies increase by 2 cycles. Measured values are unchanged.
  - The synchronizer flops reset to 0.
- Not defined: `sqr_in` is used directly and is assumed synchronous to `clk`.

## Test plan
- Generator `m=3`, `n=5`, `meas_ready=1` → first result `high_m_meas=3`, `low_n_meas=5`, `meas_valid` for one cycle every 80 cycles, `overrun=0`.
- Generator `m=1`, `n=15` → results 1/15. Then `m=15`, `n=1` → 15/1. The first period after the change may be a mixed value; every period after it is exact.
- `m=2`, `n=2`, `meas_ready=0` for 3 periods → the first result is held unchanged, `overrun=1`. Raise `meas_ready` for 1 cycle → transfer happens, `meas_valid=0` next cycle, `overrun=0`.
- `m=0` (constant low) → `stuck_lo=1` 200 cycles after the last edge and `meas_valid` never rises. Set `m=4`, `n=4` → `stuck_lo` clears at the rise, and the first result 4/4 arrives 80 cycles later.
- Assert `rst_n=0` mid-MEAS_LO with `meas_valid=1` → all outputs go to 0 asynchronously. After release, no result until a full high phase and a full low phase have been measured.
- Publish in the same cycle as a transfer → the new data is loaded, `meas_valid` stays 1 and `overrun` stays 0.

Source files
------------

// File: rtl/sqr_wav_meas_if.sv
// -----------------------------------------------------------------------------
// sqr_wav_meas_if
// Result channel of the square-wave measurement stage: a valid/ready
// handshake carrying one measured high/low period pair.
//
// Signals:
//   meas_valid  - producer holds a result
//   meas_ready  - consumer accepts the result this cycle
//   high_m_meas - measured high time, 100 ns units (0..15)
//   low_n_meas  - measured low time, 100 ns units (0..15)
//
// Modports:
//   master - measurement block (drives valid/data, samples ready)
//   slave  - consumer (samples valid/data, drives ready)
// -----------------------------------------------------------------------------
interface sqr_wav_meas_if;
    logic       meas_valid;
    logic       meas_ready;
    logic [3:0] high_m_meas;
    logic [3:0] low_n_meas;

    modport master (
        output meas_valid,
        output high_m_meas,
        output low_n_meas,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  high_m_meas,
        input  low_n_meas,
        output meas_ready
    );
endinterface

// File: rtl/sqr_wav_meas.sv
// -----------------------------------------------------------------------------
// sqr_wav_meas
// Measures each complete high/low period of a square wave in units of
// SQR_STATE_NS and publishes the pair over a valid/ready channel. Flags a
// level that has not toggled for TIMEOUT_UNITS units as stuck high/low.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   sqr_in   - square wave under measurement
//   meas     - result channel (sqr_wav_meas_if.master)
//   overrun  - sticky: a completed period was dropped under backpressure
//   stuck_hi - sqr_in high for at least TIMEOUT_UNITS units
//   stuck_lo - sqr_in low for at least TIMEOUT_UNITS units
//
// Build option:
//   SQR_MEAS_SYNC_EN - inserts a 2-flop synchronizer on sqr_in for
//                      asynchronous sources (+2 cycles edge latency).
// -----------------------------------------------------------------------------
module sqr_wav_meas #(
    parameter int SQR_STATE_NS  = 100,
    parameter int CLK_NS        = 10,
    parameter int TIMEOUT_UNITS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sqr_in,
    sqr_wav_meas_if.master    meas,
    output logic              overrun,
    output logic              stuck_hi,
    output logic              stuck_lo
);

    localparam int DIV = SQR_STATE_NS / CLK_NS;
    localparam int DW  = $clog2(DIV);
    localparam int UW  = $clog2(TIMEOUT_UNITS + 1);

    localparam logic [1:0] ST_WAIT    = 2'd0;
    localparam logic [1:0] ST_MEAS_HI = 2'd1;
    localparam logic [1:0] ST_MEAS_LO = 2'd2;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sqr_s;

`ifdef SQR_MEAS_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sqr_in;
            sync2_q <= sync1_q;
        end
    end

    assign sqr_s = sync2_q;
`else
    assign sqr_s = sqr_in;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q,    state_d;
    logic          prev_q;
    logic [DW-1:0] div_q,      div_d;
    logic [UW-1:0] units_q,    units_d;
    logic [3:0]    hi_hold_q,  hi_hold_d;
    logic          valid_q,    valid_d;
    logic [3:0]    high_q,     high_d;
    logic [3:0]    low_q,      low_d;
    logic          overrun_q,  overrun_d;
    logic          stuck_hi_q, stuck_hi_d;
    logic          stuck_lo_q, stuck_lo_d;

    logic          edge_det, rise, fall, timeout, publish, xfer;
    logic [3:0]    len;

    assign edge_det = sqr_s ^ prev_q;
    assign rise     = edge_det &  sqr_s;
    assign fall     = edge_det & ~sqr_s;
    assign timeout  = (units_q == UW'(TIMEOUT_UNITS));
    assign xfer     = valid_q & meas.meas_ready;

    // Length of the phase that ends on this edge: units_q still reflects
    // all cycles spent at the old level.
    assign len = (units_q > UW'(15)) ? 4'd15 : units_q[3:0];

    // Cycle count is kept as units*DIV + div to avoid a divider.
    always_comb begin
        div_d   = div_q;
        units_d = units_q;
        if (edge_det) begin
            // The edge cycle is the first cycle of the new phase.
            div_d   = DW'(1);
            units_d = '0;
        end else if (!timeout) begin
            if (div_q == DW'(DIV - 1)) begin
                div_d   = '0;
                units_d = units_q + UW'(1);
            end else begin
                div_d   = div_q + DW'(1);
            end
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        hi_hold_d  = hi_hold_q;
        stuck_hi_d = stuck_hi_q;
        stuck_lo_d = stuck_lo_q;
        publish    = 1'b0;

        if (edge_det) begin
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end

        case (state_q)
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_MEAS_HI;
                end else if (!edge_det && timeout) begin
                    if (sqr_s) stuck_hi_d = 1'b1;
                    else       stuck_lo_d = 1'b1;
                end
            end
            ST_MEAS_HI: begin
                if (fall) begin
                    hi_hold_d = len;
                    state_d   = ST_MEAS_LO;
                end else if (!edge_det && timeout) begin
                    stuck_hi_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_MEAS_LO: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = ST_MEAS_HI;
                end else if (!edge_det && timeout) begin
                    stuck_lo_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Output holding register: a new result is accepted only when the slot
    // is empty or is being emptied in this same cycle.
    always_comb begin
        valid_d   = valid_q;
        high_d    = high_q;
        low_d     = low_q;
        overrun_d = overrun_q;

        if (xfer) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (publish) begin
            if (!valid_q || xfer) begin
                valid_d = 1'b1;
                high_d  = hi_hold_q;
                low_d   = len;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            prev_q     <= 1'b0;
            div_q      <= '0;
            units_q    <= '0;
            hi_hold_q  <= '0;
            valid_q    <= 1'b0;
            high_q     <= '0;
            low_q      <= '0;
            overrun_q  <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= sqr_s;
            div_q      <= div_d;
            units_q    <= units_d;
            hi_hold_q  <= hi_hold_d;
            valid_q    <= valid_d;
            high_q     <= high_d;
            low_q      <= low_d;
            overrun_q  <= overrun_d;
            stuck_hi_q <= stuck_hi_d;
            stuck_lo_q <= stuck_lo_d;
        end
    end

    assign meas.meas_valid  = valid_q;
    assign meas.high_m_meas = high_q;
    assign meas.low_n_meas  = low_q;
    assign overrun          = overrun_q;
    assign stuck_hi         = stuck_hi_q;
    assign stuck_lo         = stuck_lo_q;

endmodule

// File: tb/tb_sqr_wav_meas.sv
// -----------------------------------------------------------------------------
// tb_sqr_wav_meas
// Directed bench for sqr_wav_meas (default parameters: DIV=10, timeout 20
// units = 200 cycles). A table of high/low cycle counts is streamed as a
// continuous wave with the consumer always ready; hand-written sequences
// cover backpressure, same-cycle publish/transfer, stuck detection and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sqr_wav_meas;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sqr_in = 1'b0;
    logic overrun, stuck_hi, stuck_lo;

    sqr_wav_meas_if mif ();

    sqr_wav_meas dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sqr_in   (sqr_in),
        .meas     (mif.master),
        .overrun  (overrun),
        .stuck_hi (stuck_hi),
        .stuck_lo (stuck_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         hi_cyc;
        int         lo_cyc;
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int         errors = 0;
    int         checks = 0;
    int         xfer_cnt = 0;
    logic [3:0] last_hi = '0;
    logic [3:0] last_lo = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A transfer is recorded from the values present just before the edge
    // that performs it; outputs are then sampled 1 ns after that edge.
    task automatic tick();
        if (mif.meas_valid === 1'b1 && mif.meas_ready === 1'b1) begin
            xfer_cnt++;
            last_hi = mif.high_m_meas;
            last_lo = mif.low_n_meas;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            sqr_in = lvl;
            tick();
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        sqr_in         = 1'b0;
        mif.meas_ready = rdy;
        tick();
        tick();
        rst_n    = 1'b1;
        xfer_cnt = 0;
    endtask

    initial begin
        vecs[0]  = '{30,  50,  4'd3,  4'd5};
        vecs[1]  = '{10,  150, 4'd1,  4'd15};
        vecs[2]  = '{150, 10,  4'd15, 4'd1};
        vecs[3]  = '{20,  20,  4'd2,  4'd2};
        vecs[4]  = '{19,  21,  4'd1,  4'd2};
        vecs[5]  = '{9,   11,  4'd0,  4'd1};
        vecs[6]  = '{1,   1,   4'd0,  4'd0};
        vecs[7]  = '{2,   3,   4'd0,  4'd0};
        vecs[8]  = '{160, 199, 4'd15, 4'd15};
        vecs[9]  = '{199, 5,   4'd15, 4'd0};
        vecs[10] = '{10,  10,  4'd1,  4'd1};

        mif.meas_ready = 1'b1;

        // ---------------- reset state ----------------
        do_reset(1'b1);
        check("rst_valid",    int'(mif.meas_valid),  0);
        check("rst_high",     int'(mif.high_m_meas), 0);
        check("rst_low",      int'(mif.low_n_meas),  0);
        check("rst_overrun",  int'(overrun),         0);
        check("rst_stuck_hi", int'(stuck_hi),        0);
        check("rst_stuck_lo", int'(stuck_lo),        0);

        // ---------------- table: continuous wave, ready=1 ----------------
        drive(1'b0, 5);
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].hi_cyc);
            drive(1'b0, vecs[i].lo_cyc);
            check($sformatf("tbl%0d_xfers", i), xfer_cnt, i);
            if (i > 0) begin
                check($sformatf("tbl%0d_high", i - 1), int'(last_hi), int'(vecs[i-1].exp_hi));
                check($sformatf("tbl%0d_low",  i - 1), int'(last_lo), int'(vecs[i-1].exp_lo));
            end
        end
        drive(1'b1, 2);
        check("tbl_last_xfers", xfer_cnt, NV);
        check("tbl_last_high", int'(last_hi), int'(vecs[NV-1].exp_hi));
        check("tbl_last_low",  int'(last_lo), int'(vecs[NV-1].exp_lo));
        check("tbl_valid_one_cycle", int'(mif.meas_valid), 0);
        check("tbl_overrun", int'(overrun), 0);

        // ---------------- backpressure and overrun ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        drive(1'b1, 20);
        drive(1'b0, 30);
        drive(1'b1, 40);                 // publishes 2/3, held
        check("bp_first_valid",   int'(mif.meas_valid), 1);
        check("bp_first_overrun", int'(overrun), 0);
        drive(1'b0, 40);
        drive(1'b1, 20);                 // 4/4 dropped
        drive(1'b0, 20);
        drive(1'b1, 5);                  // 2/2 dropped
        check("bp_held_valid", int'(mif.meas_valid),  1);
        check("bp_held_high",  int'(mif.high_m_meas), 2);
        check("bp_held_low",   int'(mif.low_n_meas),  3);
        check("bp_overrun",    int'(overrun),         1);
        mif.meas_ready = 1'b1;
        tick();
        mif.meas_ready = 1'b0;
        check("bp_xfer_count",   xfer_cnt, 1);
        check("bp_after_valid",  int'(mif.meas_valid), 0);
        check("bp_after_overrun", int'(overrun), 0);

        // ---------------- publish in same cycle as transfer ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 30);                 // publishes 2/2, held
        drive(1'b0, 10);
        mif.meas_ready = 1'b1;
        sqr_in = 1'b1;
        tick();                          // transfer of 2/2 + publish of 3/1
        mif.meas_ready = 1'b0;
        check("same_old_xfer_high", int'(last_hi), 2);
        check("same_valid",   int'(mif.meas_valid),  1);
        check("same_high",    int'(mif.high_m_meas), 3);
        check("same_low",     int'(mif.low_n_meas),  1);
        check("same_overrun", int'(overrun),         0);
        drive(1'b1, 3);
        check("same_stable_high", int'(mif.high_m_meas), 3);
        check("same_stable_low",  int'(mif.low_n_meas),  1);

        // ---------------- stuck low then recovery ----------------
        do_reset(1'b1);
        drive(1'b0, 5);
        drive(1'b1, 40);
        drive(1'b0, 200);                // fall edge is the first of these
        check("stuck_lo_early", int'(stuck_lo), 0);
        drive(1'b0, 1);
        check("stuck_lo_set",    int'(stuck_lo), 1);
        check("stuck_lo_no_hi",  int'(stuck_hi), 0);
        drive(1'b0, 50);
        check("stuck_lo_hold",   int'(stuck_lo), 1);
        check("stuck_lo_novalid", xfer_cnt + int'(mif.meas_valid), 0);
        drive(1'b1, 1);
        check("stuck_lo_clear",  int'(stuck_lo), 0);
        drive(1'b1, 39);
        drive(1'b0, 40);
        check("recov_no_early", xfer_cnt + int'(mif.meas_valid), 0);
        drive(1'b1, 1);
        check("recov_valid", int'(mif.meas_valid),  1);
        check("recov_high",  int'(mif.high_m_meas), 4);
        check("recov_low",   int'(mif.low_n_meas),  4);

        // ---------------- stuck high ----------------
        do_reset(1'b1);
        drive(1'b0, 3);
        drive(1'b1, 200);
        check("stuck_hi_early", int'(stuck_hi), 0);
        drive(1'b1, 1);
        check("stuck_hi_set",   int'(stuck_hi), 1);
        drive(1'b0, 1);
        check("stuck_hi_clear", int'(stuck_hi), 0);

        // ---------------- async reset mid MEAS_LO ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 20);                 // publishes 2/2, held
        drive(1'b0, 10);
        check("arst_pre_valid", int'(mif.meas_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(mif.meas_valid),  0);
        check("arst_high",  int'(mif.high_m_meas), 0);
        check("arst_low",   int'(mif.low_n_meas),  0);
        check("arst_flags", int'({overrun, stuck_hi, stuck_lo}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 10);
        drive(1'b1, 30);
        drive(1'b0, 30);
        check("arst_no_early", int'(mif.meas_valid), 0);
        drive(1'b1, 1);
        check("arst_new_valid", int'(mif.meas_valid),  1);
        check("arst_new_high",  int'(mif.high_m_meas), 3);
        check("arst_new_low",   int'(mif.low_n_meas),  3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
